seg7_scan_2digit: RTL and testbench

//  Downstream display stage for the two-digit BCD counter. Takes tens/ones BCD digits and

---
 rtl/seg7_scan_2digit_pkg.sv | 35 +++
 rtl/seg7_scan_2digit_bcd_to_seg7.sv | 28 ++
 rtl/seg7_scan_2digit.sv | 97 +++++++++
 tb/tb_seg7_scan_2digit.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/seg7_scan_2digit_pkg.sv
// Shared definitions for the 2-digit 7-segment scanner.
//   - Segment patterns are {g,f,e,d,c,b,a} and active-high.
//   - dig_sel_e is the scan digit index: ones = 0, tens = 1.
//   - disp_t is one registered display state (anodes + segments).
package seg7_scan_2digit_pkg;

    localparam logic [6:0] SEG_0    = 7'b0111111;
    localparam logic [6:0] SEG_1    = 7'b0000110;
    localparam logic [6:0] SEG_2    = 7'b1011011;
    localparam logic [6:0] SEG_3    = 7'b1001111;
    localparam logic [6:0] SEG_4    = 7'b1100110;
    localparam logic [6:0] SEG_5    = 7'b1101101;
    localparam logic [6:0] SEG_6    = 7'b1111101;
    localparam logic [6:0] SEG_7    = 7'b0000111;
    localparam logic [6:0] SEG_8    = 7'b1111111;
    localparam logic [6:0] SEG_9    = 7'b1101111;
    localparam logic [6:0] SEG_DASH = 7'b1000000;
    localparam logic [6:0] SEG_OFF  = 7'b0000000;

    typedef enum logic {
        DIG_ONES = 1'b0,
        DIG_TENS = 1'b1
    } dig_sel_e;

    typedef struct packed {
        logic [1:0] an;
        logic [6:0] seg;
    } disp_t;

    // Active-high one-hot anode enable for the selected digit.
    function automatic logic [1:0] an_onehot(input dig_sel_e s);
        return (s == DIG_TENS) ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/seg7_scan_2digit_bcd_to_seg7.sv
// Combinational BCD to 7-segment decoder.
//   bcd : 4-bit digit in
//   seg : active-high pattern {g,f,e,d,c,b,a}; codes 10-15 show a dash
module bcd_to_seg7
    import seg7_scan_2digit_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_DASH;
        case (bcd)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/seg7_scan_2digit.sv
// Two-digit common-anode 7-segment scanner.
// Time-multiplexes a tens/ones BCD pair onto one shared segment bus with a
// one-clock all-off guard between digits, frame-coherent digit capture and
// optional leading-zero blanking.
//   clock      : system clock, rising edge
//   reset      : synchronous, active-high
//   dig1/dig0  : tens/ones BCD digits, synchronous to clock
//   blank_lead : blank the tens digit when the captured tens value is 0
//   seg        : segments {g,f,e,d,c,b,a}, polarity per ACTIVE_LOW
//   an         : digit enables, an[0]=ones, an[1]=tens, polarity per ACTIVE_LOW
module seg7_scan_2digit
    import seg7_scan_2digit_pkg::*;
#(
    parameter int REFRESH_DIV = 100000,
    parameter bit ACTIVE_LOW  = 1'b1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] dig1,
    input  logic [3:0] dig0,
    input  logic       blank_lead,
    output logic [6:0] seg,
    output logic [1:0] an
);

    localparam int             CW      = $clog2(REFRESH_DIV);
    localparam logic [CW-1:0]  CNT_MAX = CW'(REFRESH_DIV - 1);

    logic [CW-1:0] cnt;
    logic          tick;
    dig_sel_e      sel;
    logic [3:0]    sh1, sh0;
    logic [3:0]    cur_bcd;
    logic [6:0]    cur_pat;
    disp_t         disp_nxt;
    disp_t         disp_pins;
    disp_t         disp_off_pins;

    assign tick = (cnt == CNT_MAX);

    // Prescaler, digit select and frame shadow registers. Capturing only on
    // the tick that ends the tens slot means both digits of a frame always
    // come from the same counter value.
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt <= '0;
            sel <= DIG_ONES;
            sh1 <= 4'd0;
            sh0 <= 4'd0;
        end else begin
            cnt <= tick ? '0 : cnt + CW'(1);
            if (tick) begin
                sel <= (sel == DIG_ONES) ? DIG_TENS : DIG_ONES;
                if (sel == DIG_TENS) begin
                    sh1 <= dig1;
                    sh0 <= dig0;
                end
            end
        end
    end

    assign cur_bcd = (sel == DIG_TENS) ? sh1 : sh0;

    bcd_to_seg7 u_dec (
        .bcd (cur_bcd),
        .seg (cur_pat)
    );

    // Next display state, internal active-high. The tick edge forces the
    // guard cycle so the old digit's anode is off before the new one drives.
    always_comb begin
        disp_nxt.an  = 2'b00;
        disp_nxt.seg = SEG_OFF;
        if (!tick) begin
            disp_nxt.an = an_onehot(sel);
            if (sel == DIG_TENS && blank_lead && sh1 == 4'd0)
                disp_nxt.seg = SEG_OFF;
            else
                disp_nxt.seg = cur_pat;
        end
    end

    // Board polarity applied before the output register so pins are glitch-free.
    assign disp_pins     = ACTIVE_LOW ? ~disp_nxt : disp_nxt;
    assign disp_off_pins = ACTIVE_LOW ? '1 : '0;

    always_ff @(posedge clock) begin
        if (reset) begin
            an  <= disp_off_pins.an;
            seg <= disp_off_pins.seg;
        end else begin
            an  <= disp_pins.an;
            seg <= disp_pins.seg;
        end
    end

endmodule

// File: tb/tb_seg7_scan_2digit.sv
module tb_seg7_scan_2digit;

    localparam int D = 4;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] dig1 = 4'd0, dig0 = 4'd0;
    logic       blank_lead = 1'b0;
    logic [6:0] seg_h, seg_l;
    logic [1:0] an_h, an_l;

    always #5 clock = ~clock;

    seg7_scan_2digit #(.REFRESH_DIV(D), .ACTIVE_LOW(1'b0)) u_dut_hi (
        .clock(clock), .reset(reset), .dig1(dig1), .dig0(dig0),
        .blank_lead(blank_lead), .seg(seg_h), .an(an_h)
    );

    seg7_scan_2digit #(.REFRESH_DIV(D), .ACTIVE_LOW(1'b1)) u_dut_lo (
        .clock(clock), .reset(reset), .dig1(dig1), .dig0(dig0),
        .blank_lead(blank_lead), .seg(seg_l), .an(an_l)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: t counts non-reset edges since the last reset. Each
    // digit slot is D edges, ones first, the last edge of each slot is the
    // guard; the frame's digits are captured on the guard edge ending tens.
    int         t = 0;
    logic [3:0] m_sh1 = 4'd0, m_sh0 = 4'd0;
    logic [1:0] exp_an = 2'b00;
    logic [6:0] exp_seg = 7'b0;

    function automatic logic [6:0] ref_pat(input logic [3:0] d);
        logic [6:0] pats [10];
        pats = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
        return (d <= 4'd9) ? pats[d] : 7'h40;
    endfunction

    task automatic step();
        int phase, slot;
        @(posedge clock);
        if (reset) begin
            t = 0; m_sh1 = 4'd0; m_sh0 = 4'd0;
            exp_an = 2'b00; exp_seg = 7'b0;
        end else begin
            phase = t % D;
            slot  = (t / D) % 2;
            if (phase == D - 1) begin
                exp_an = 2'b00; exp_seg = 7'b0;
                if (slot == 1) begin m_sh1 = dig1; m_sh0 = dig0; end
            end else if (slot == 0) begin
                exp_an = 2'b01; exp_seg = ref_pat(m_sh0);
            end else begin
                exp_an  = 2'b10;
                exp_seg = (blank_lead && m_sh1 == 4'd0) ? 7'b0 : ref_pat(m_sh1);
            end
            t++;
        end
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; dig1 = 4'd5; dig0 = 4'd7; blank_lead = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            n_checks++;
            if (an_h !== 2'b00 || seg_h !== 7'b0)
                $display("FAIL reset_hi cyc=%0d got an=%b seg=%b want an=00 seg=0000000", i, an_h, seg_h);
            else n_pass++;
            n_checks++;
            if (an_l !== 2'b11 || seg_l !== 7'b1111111)
                $display("FAIL reset_lo cyc=%0d got an=%b seg=%b want an=11 seg=1111111", i, an_l, seg_l);
            else n_pass++;
        end
        reset = 1'b0;
        step();
        n_checks++;
        if (an_h !== 2'b01 || seg_h !== 7'b0111111)
            $display("FAIL reset_first got an=%b seg=%b want an=01 seg=0111111", an_h, seg_h);
        else n_pass++;
    endtask

    task automatic test_scan();
        reset = 1'b1; step(); reset = 1'b0;
        dig1 = 4'd4; dig0 = 4'd2;
        for (int i = 0; i < 24; i++) begin
            step();
            n_checks++;
            if (an_h !== exp_an || seg_h !== exp_seg)
                $display("FAIL scan_hi t=%0d got an=%b seg=%b want an=%b seg=%b", t-1, an_h, seg_h, exp_an, exp_seg);
            else n_pass++;
            n_checks++;
            if (an_l !== ~exp_an || seg_l !== ~exp_seg)
                $display("FAIL scan_lo t=%0d got an=%b seg=%b want an=%b seg=%b", t-1, an_l, seg_l, ~exp_an, ~exp_seg);
            else n_pass++;
            if (t - 1 == 8) begin
                n_checks++;
                if (an_h !== 2'b01 || seg_h !== 7'b1011011)
                    $display("FAIL scan_ones_cap got an=%b seg=%b want an=01 seg=1011011", an_h, seg_h);
                else n_pass++;
            end
            if (t - 1 == 12) begin
                n_checks++;
                if (an_h !== 2'b10 || seg_h !== 7'b1100110)
                    $display("FAIL scan_tens_cap got an=%b seg=%b want an=10 seg=1100110", an_h, seg_h);
                else n_pass++;
            end
        end
    endtask

    // dig0 changes mid-frame; the model only sees it at the capture edge.
    task automatic test_capture_hold();
        dig0 = 4'd3;
        for (int i = 0; i < 4 * D; i++) begin
            if ((t % (2 * D)) == D + 1) dig0 = 4'd8;  // tens slot
            if ((t % (2 * D)) == 1 && i > 2 * D) dig0 = 4'd6;  // ones slot
            step();
            n_checks++;
            if (an_h !== exp_an || seg_h !== exp_seg)
                $display("FAIL hold t=%0d got an=%b seg=%b want an=%b seg=%b", t-1, an_h, seg_h, exp_an, exp_seg);
            else n_pass++;
        end
    endtask

    task automatic test_blanking();
        blank_lead = 1'b1; dig1 = 4'd0; dig0 = 4'd9;
        for (int i = 0; i < 6 * D; i++) begin
            if (i == 4 * D) blank_lead = 1'b0;
            step();
            n_checks++;
            if (an_h !== exp_an || seg_h !== exp_seg)
                $display("FAIL blank t=%0d got an=%b seg=%b want an=%b seg=%b", t-1, an_h, seg_h, exp_an, exp_seg);
            else n_pass++;
        end
    endtask

    task automatic test_dash();
        dig1 = 4'd1; dig0 = 4'hC;
        for (int i = 0; i < 4 * D; i++) begin
            step();
            n_checks++;
            if (an_l !== ~exp_an || seg_l !== ~exp_seg)
                $display("FAIL dash t=%0d got an=%b seg=%b want an=%b seg=%b", t-1, an_l, seg_l, ~exp_an, ~exp_seg);
            else n_pass++;
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            dig1 = 4'($urandom_range(0, 15));
            dig0 = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0) dig1 = 4'd0;
            blank_lead = 1'($urandom_range(0, 1));
            step();
            n_checks++;
            if (an_h !== exp_an || seg_h !== exp_seg)
                $display("FAIL rand_hi t=%0d got an=%b seg=%b want an=%b seg=%b", t-1, an_h, seg_h, exp_an, exp_seg);
            else n_pass++;
            n_checks++;
            if (an_l !== ~exp_an || seg_l !== ~exp_seg)
                $display("FAIL rand_lo t=%0d got an=%b seg=%b want an=%b seg=%b", t-1, an_l, seg_l, ~exp_an, ~exp_seg);
            else n_pass++;
        end
    endtask

    task automatic test_midframe_reset();
        int guard_cnt;
        blank_lead = 1'b0; dig1 = 4'd7; dig0 = 4'd5;
        guard_cnt = 0;
        while (!(an_h == 2'b10 && (t % D) < D - 2) && guard_cnt < 40) begin
            step();
            guard_cnt++;
        end
        n_checks++;
        if (an_h !== 2'b10)
            $display("FAIL mreset_setup got an=%b want an=10 (tens slot not reached)", an_h);
        else n_pass++;
        reset = 1'b1;
        step();
        n_checks++;
        if (an_h !== 2'b00 || seg_h !== 7'b0)
            $display("FAIL mreset_off got an=%b seg=%b want an=00 seg=0000000", an_h, seg_h);
        else n_pass++;
        reset = 1'b0;
        for (int i = 0; i < D; i++) begin
            step();
            n_checks++;
            if (an_h !== exp_an || seg_h !== exp_seg)
                $display("FAIL mreset_run t=%0d got an=%b seg=%b want an=%b seg=%b", t-1, an_h, seg_h, exp_an, exp_seg);
            else n_pass++;
            if (i == 0) begin
                n_checks++;
                if (an_h !== 2'b01 || seg_h !== 7'b0111111)
                    $display("FAIL mreset_first got an=%b seg=%b want an=01 seg=0111111", an_h, seg_h);
                else n_pass++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_scan();
        test_capture_hold();
        test_blanking();
        test_dash();
        test_random();
        test_midframe_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
